// File: rtl/mac_lanes.sv
// mac_lanes: LANES independent signed multiply-accumulate lanes computing a
// dot product over a len-beat job. Each result is rounded half-up,
// right-shifted by FRAC_BITS and saturated to OUT_W bits, with a per-lane
// clip flag.
module mac_lanes #(
  parameter int DATA_W    = 16,
  parameter int LANES     = 4,
  parameter int ACC_W     = 40,
  parameter int LEN_W     = 8,
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DATA_W-1:0]  a,
  input  logic [LANES*DATA_W-1:0]  b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   out_data,
  output logic [LANES-1:0]         sat,
  output logic                     busy
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned RND_W  = ACC_W + 1;

  // Rounding constant and saturation bounds at rounding width.
  localparam logic signed [RND_W-1:0] HALF = RND_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [RND_W-1:0] MAXV = {{(RND_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RND_W-1:0] MINV = {{(RND_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t           state_q, state_nxt;
  logic [LEN_W-1:0] cnt_q, cnt_nxt;
  logic             drain_q, drain_nxt;
  logic             accept_c;
  logic             clear_c;
  logic             load_c;
  logic             pv_q;

  // Next-state, beat counter and datapath control.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    drain_nxt = drain_q;
    accept_c  = 1'b0;
    clear_c   = 1'b0;
    load_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          clear_c   = 1'b1;
          cnt_nxt   = len;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          accept_c = 1'b1;
          cnt_nxt  = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_nxt = DRAIN;
            drain_nxt = 1'b0;
          end
        end
      end
      DRAIN: begin
        // Two cycles let the last product reach the accumulator.
        if (drain_q) begin
          state_nxt = RESULT;
          load_c    = 1'b1;
          drain_nxt = 1'b0;
        end else begin
          drain_nxt = 1'b1;
        end
      end
      RESULT: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and state-decoded handshake/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      drain_q   <= drain_nxt;
      in_ready  <= (state_nxt == ACCUM);
      out_valid <= (state_nxt == RESULT);
      busy      <= (state_nxt != IDLE);
    end
  end

  // Product-valid bit travels alongside the stage-1 product registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv_q <= 1'b0;
    end else begin
      pv_q <= accept_c;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DATA_W-1:0] a_l;
    logic signed [DATA_W-1:0] b_l;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [RND_W-1:0]  rnd_c;
    logic signed [RND_W-1:0]  shf_c;
    logic                     hi_c;
    logic                     lo_c;
    logic [OUT_W-1:0]         res_q;
    logic                     sat_q;

    assign a_l = $signed(a[i*DATA_W +: DATA_W]);
    assign b_l = $signed(b[i*DATA_W +: DATA_W]);

    // Stage 1: full-precision product of an accepted beat.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        prod_q <= '0;
      end else if (accept_c) begin
        prod_q <= PROD_W'(a_l) * PROD_W'(b_l);
      end
    end

    // Stage 2: sign-extended accumulate, wrapping silently on overflow.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc_q <= '0;
      end else if (clear_c) begin
        acc_q <= '0;
      end else if (pv_q) begin
        acc_q <= acc_q + ACC_W'(prod_q);
      end
    end

    // Round half-up, scale down, and detect clipping.
    always_comb begin
      rnd_c = RND_W'(acc_q) + HALF;
      shf_c = rnd_c >>> FRAC_BITS;
      hi_c  = (shf_c > MAXV);
      lo_c  = (shf_c < MINV);
    end

    // Result register, loaded only on entry to RESULT.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        res_q <= '0;
        sat_q <= 1'b0;
      end else if (load_c) begin
        if (hi_c) begin
          res_q <= MAXV[OUT_W-1:0];
          sat_q <= 1'b1;
        end else if (lo_c) begin
          res_q <= MINV[OUT_W-1:0];
          sat_q <= 1'b1;
        end else begin
          res_q <= shf_c[OUT_W-1:0];
          sat_q <= 1'b0;
        end
      end
    end

    assign out_data[i*OUT_W +: OUT_W] = res_q;
    assign sat[i]                     = sat_q;
  end

endmodule

// File: tb/tb_mac_lanes.sv
// Scoreboard bench for mac_lanes: the driver records accepted beats and
// pushes the arithmetic result expected for each job; a monitor pops and
// compares on every output handshake.
module tb_mac_lanes;

  localparam int DATA_W    = 16;
  localparam int LANES     = 4;
  localparam int ACC_W     = 40;
  localparam int LEN_W     = 8;
  localparam int OUT_W     = 16;
  localparam int FRAC_BITS = 8;
  localparam int VW        = LANES * DATA_W;
  localparam int OW        = LANES * OUT_W;

  typedef struct {
    logic [OW-1:0]    data;
    logic [LANES-1:0] sat;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [VW-1:0]    a = '0;
  logic [VW-1:0]    b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OW-1:0]    out_data;
  logic [LANES-1:0] sat;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t          exp_q[$];
  logic [VW-1:0] ba[$];
  logic [VW-1:0] bb[$];
  logic [VW-1:0] src_a[8];
  logic [VW-1:0] src_b[8];

  mac_lanes #(
    .DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W),
    .LEN_W(LEN_W), .OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact dot product, wrapped to ACC_W, rounded half-up, clipped.
  function automatic exp_t model();
    exp_t   e;
    longint s, r, pa, pb;
    longint maxv = (longint'(1) <<< (OUT_W - 1)) - 1;
    longint minv = -(longint'(1) <<< (OUT_W - 1));
    e.data = '0;
    e.sat  = '0;
    for (int l = 0; l < LANES; l++) begin
      s = 0;
      for (int k = 0; k < ba.size(); k++) begin
        pa = longint'($signed(ba[k][l*DATA_W +: DATA_W]));
        pb = longint'($signed(bb[k][l*DATA_W +: DATA_W]));
        s  = s + pa * pb;
      end
      s = (s <<< (64 - ACC_W)) >>> (64 - ACC_W);
      r = (s + (longint'(1) <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
      if (r > maxv) begin
        r = maxv;
        e.sat[l] = 1'b1;
      end else if (r < minv) begin
        r = minv;
        e.sat[l] = 1'b1;
      end
      e.data[l*OUT_W +: OUT_W] = r[OUT_W-1:0];
    end
    return e;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0]     v;
    logic [DATA_W-1:0] x;
    for (int l = 0; l < LANES; l++) begin
      if ($urandom_range(0, 3) == 0) x = DATA_W'($urandom);
      else x = DATA_W'(int'($urandom_range(0, 511)) - 256);
      v[l*DATA_W +: DATA_W] = x;
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] lane_vec(input int lane, input int val);
    logic [VW-1:0] v = '0;
    v[lane*DATA_W +: DATA_W] = DATA_W'(val);
    return v;
  endfunction

  // Issue a job, feed beats with the chosen gap pattern, push the expected result.
  task automatic run_job(input int n, input int gap_mode, input bit noise, input bit use_src);
    int got = 0;
    int guard = 0;
    bit tog = 1'b1;
    ba.delete();
    bb.delete();
    @(posedge clk); #1;
    start = 1'b1;
    len   = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    while (got < n && guard < 2000) begin
      guard++;
      case (gap_mode)
        0: in_valid = 1'b1;
        1: begin in_valid = tog; tog = ~tog; end
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      a = use_src ? src_a[got] : rand_vec();
      b = use_src ? src_b[got] : rand_vec();
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        len   = LEN_W'($urandom_range(1, 255));
      end
      if (in_valid && in_ready) begin
        ba.push_back(a);
        bb.push_back(b);
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (got < n) chk("beat_timeout", 64'(got), 64'(n));
    exp_q.push_back(model());
    // Two drain cycles, then the result appears.
    @(negedge clk); chk("latency_d1", 64'(out_valid), 64'd0);
    @(negedge clk); chk("latency_d2", 64'(out_valid), 64'd0);
    @(negedge clk); chk("latency_res", 64'(out_valid), 64'd1);
  endtask

  // Accept the result immediately and wait for the return to IDLE.
  task automatic finish_job();
    int guard = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    while (out_valid && guard < 20) begin
      guard++;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk("handshake_idle", 64'(busy), 64'd0);
  endtask

  // Hold back the consumer, then release it together with a start pulse.
  task automatic finish_hold(input int cycles);
    logic [OW-1:0]    d;
    logic [LANES-1:0] s;
    @(posedge clk); #1;
    d = out_data;
    s = sat;
    for (int i = 0; i < cycles; i++) begin
      start = 1'b1;
      len   = LEN_W'($urandom_range(1, 255));
      @(negedge clk);
      chk("hold_data", 64'(out_data), 64'(d));
      chk("hold_sat", 64'(sat), 64'(s));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    start     = 1'b1;
    len       = LEN_W'(5);
    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = 1'b0;
    chk("release_valid", 64'(out_valid), 64'd0);
    chk("release_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("start_at_handshake", 64'(busy), 64'd0);
    chk("data_holds", 64'(out_data), 64'(d));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_sat"}, 64'(sat), 64'd0);
  endtask

  // Monitor: one comparison against the scoreboard per output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %0h expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("sat", 64'(sat), 64'(e.sat));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // len=0 start in IDLE is ignored.
    @(posedge clk); #1;
    start = 1'b1;
    len   = '0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("len0_busy", 64'(busy), 64'd0);
    chk("len0_in_ready", 64'(in_ready), 64'd0);

    // Lane0 dot product of three beats gives 131072 >> 8 = 512.
    src_a[0] = lane_vec(0, 256);  src_b[0] = lane_vec(0, 256);
    src_a[1] = lane_vec(0, 512);  src_b[1] = lane_vec(0, 256);
    src_a[2] = lane_vec(0, -256); src_b[2] = lane_vec(0, 256);
    run_job(3, 0, 1'b0, 1'b1);
    finish_job();
    chk("dot3_lane0", 64'(out_data[OUT_W-1:0]), 64'd512);
    chk("dot3_sat", 64'(sat), 64'd0);

    // Positive clip on lane1.
    src_a[0] = lane_vec(1, 32767); src_b[0] = lane_vec(1, 32767);
    run_job(1, 0, 1'b0, 1'b1);
    finish_job();
    chk("clip_lane1", 64'(out_data[OUT_W +: OUT_W]), 64'd32767);
    chk("clip_sat1", 64'(sat[1]), 64'd1);
    chk("clip_lane0", 64'(out_data[OUT_W-1:0]), 64'd0);
    chk("clip_sat0", 64'(sat[0]), 64'd0);

    // Round half-up: 384/256 -> 2, -384/256 -> -1.
    src_a[0] = lane_vec(0, 3); src_b[0] = lane_vec(0, 128);
    run_job(1, 0, 1'b0, 1'b1);
    finish_job();
    chk("round_pos", 64'(out_data[OUT_W-1:0]), 64'd2);
    src_a[0] = lane_vec(0, -3);
    run_job(1, 0, 1'b0, 1'b1);
    finish_job();
    chk("round_neg", 64'(out_data[OUT_W-1:0]), 64'(16'hffff));

    // Alternating in_valid with start noise during ACCUM.
    run_job(5, 1, 1'b1, 1'b0);
    finish_job();

    // Output backpressure for 10 cycles.
    run_job(6, 2, 1'b0, 1'b0);
    finish_hold(10);

    // Abort a 4-beat job after 2 beats.
    @(posedge clk); #1;
    start = 1'b1;
    len   = LEN_W'(4);
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    a = rand_vec();
    b = rand_vec();
    @(posedge clk); #1;
    a = rand_vec();
    b = rand_vec();
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk_all_zero("abort");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    run_job(2, 0, 1'b0, 1'b0);
    finish_job();

    // Randomized jobs with mixed gap patterns and output handling.
    for (int j = 0; j < 10; j++) begin
      run_job($urandom_range(1, 24), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 2) == 0) finish_hold($urandom_range(1, 4));
      else finish_job();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
